// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall/flush/forwarding control with memory-freeze timeout and perf counters
module hazard_control_unit #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk_hu,
  input  logic             rst_hu,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rs1_ex,
  input  logic [4:0]       rs2_ex,
  input  logic [4:0]       rd_ex,
  input  logic             DMread_ex,
  input  logic [4:0]       rd_me,
  input  logic             RUwrite_me,
  input  logic [4:0]       rd_wb,
  input  logic             RUwrite_wb,
  input  logic             branch_taken_ex,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_me,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_a_ex,
  output logic [1:0]       fwd_b_ex,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);
  state_t state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic luh, freeze;
  assign luh = DMread_ex && |rd_ex && (rd_ex == rs1_id || rd_ex == rs2_id);
  always_comb begin
    state_nxt = state;
    wait_nxt = wait_cnt;
    case (state)
      RUN: begin
        state_nxt = mem_busy ? MEM_WAIT : RUN;
        wait_nxt = mem_busy ? 8'd1 : wait_cnt;
      end
      MEM_WAIT: begin
        state_nxt = !mem_busy ? RUN : (wait_cnt < MAX_W) ? MEM_WAIT : ERROR;
        wait_nxt = !mem_busy ? 8'd0 : (wait_cnt < MAX_W) ? wait_cnt + 8'd1 : wait_cnt;
      end
      default: state_nxt = ERROR;
    endcase
  end
  // A branch squashes the dependent instruction, so it overrides the load-use bubble
  assign freeze = (state == ERROR) || mem_busy;
  assign stall_if = freeze || (!branch_taken_ex && luh);
  assign stall_id = stall_if;
  assign stall_ex = freeze;
  assign stall_me = freeze;
  assign flush_id = !freeze && branch_taken_ex;
  assign flush_ex = !freeze && (branch_taken_ex || luh);
  assign fwd_a_ex = (RUwrite_me && |rd_me && rd_me == rs1_ex) ? 2'b10 :
                    (RUwrite_wb && |rd_wb && rd_wb == rs1_ex) ? 2'b01 : 2'b00;
  assign fwd_b_ex = (RUwrite_me && |rd_me && rd_me == rs2_ex) ? 2'b10 :
                    (RUwrite_wb && |rd_wb && rd_wb == rs2_ex) ? 2'b01 : 2'b00;
  always_ff @(posedge clk_hu) begin
    if (rst_hu) begin
      state <= RUN;
      wait_cnt <= '0;
      timeout_err <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      timeout_err <= state_nxt == ERROR;
      if (stall_if && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_id && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Generates stall, flush and forwarding-select controls for IF/ID/EX/ME.
- Freezes the pipe while data memory is busy and flags a timeout when memory never releases.
- Keeps saturating stall and flush performance counters.

Parameters:
- MAX_WAIT, 16: max consecutive mem_busy cycles before timeout; legal range 2..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk_hu  in  1  clock, rising-edge
- rst_hu  in  1  synchronous reset, active-high
- rs1_id  in  5  rs1 of instruction in ID
- rs2_id  in  5  rs2 of instruction in ID
- rs1_ex  in  5  rs1 of instruction in EX
- rs2_ex  in  5  rs2 of instruction in EX
- rd_ex  in  5  destination of instruction in EX
- DMread_ex  in  1  EX instruction is a load
- rd_me  in  5  destination in ME
- RUwrite_me  in  1  ME writes the register file
- rd_wb  in  5  destination in WB
- RUwrite_wb  in  1  WB writes the register file
- branch_taken_ex  in  1  EX resolved a taken branch or jump
- mem_busy  in  1  data memory not ready this cycle
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- stall_ex  out  1  hold ID/EX register
- stall_me  out  1  hold EX/ME register
- flush_id  out  1  zero IF/ID register
- flush_ex  out  1  zero ID/EX register, inserting a bubble
- fwd_a_ex  out  2  EX operand A select: 00 = register file, 01 = WB, 10 = ME
- fwd_b_ex  out  2  EX operand B select, same encoding
- timeout_err  out  1  sticky memory-timeout flag
- stall_cnt  out  CNT_W  cycles with stall_if=1, saturating
- flush_cnt  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Clock and reset: single clock clk_hu; rst_hu is synchronous and active-high.
- State machine: states RUN, MEM_WAIT and ERROR; reset state is RUN.
- Reset values: wait_cnt=0, timeout_err=0, stall_cnt=0, flush_cnt=0. Combinational outputs are defined by the state after reset, i.e. RUN with no hazard.
- Load-use hazard: luh = DMread_ex && rd_ex!=0 && (rd_ex==rs1_id || rd_ex==rs2_id).
- Output priority, evaluated combinationally each cycle:
  1. State ERROR: stall_if/id/ex/me=1, no flush.
  2. mem_busy=1: stall_if/id/ex/me=1, flush_id=flush_ex=0. Freeze takes precedence over branch and load-use.
  3. branch_taken_ex=1: flush_id=flush_ex=1, no stall. This overrides luh because the dependent instruction is being squashed.
  4. luh=1: stall_if=stall_id=1, flush_ex=1. The bubble lasts exactly 1 cycle, since the load then moves to ME.
  5. Otherwise: all stall and flush outputs are 0.
- branch_taken_ex during a freeze is not latched. EX is frozen, so the input persists and takes effect in the first cycle with mem_busy=0.
- Transitions:
  - RUN -> MEM_WAIT when mem_busy=1; wait_cnt <= 1.
  - MEM_WAIT with mem_busy=0 -> RUN; wait_cnt <= 0.
  - MEM_WAIT with mem_busy=1 and wait_cnt < MAX_WAIT: wait_cnt increments.
  - MEM_WAIT with mem_busy=1 and wait_cnt == MAX_WAIT -> ERROR; timeout_err <= 1. This is the (MAX_WAIT+1)-th busy cycle.
  - ERROR: held until rst_hu. mem_busy is ignored.
- Forwarding, combinational:
  - fwd_a_ex = 10 if RUwrite_me && rd_me!=0 && rd_me==rs1_ex.
  - else 01 if RUwrite_wb && rd_wb!=0 && rd_wb==rs1_ex.
  - else 00.
  - fwd_b_ex is identical using rs2_ex. ME has priority over WB. x0 is never forwarded.
  - Forwarding is independent of stalls.
- Counters:
  - stall_cnt increments on every rising edge where stall_if=1.
  - flush_cnt increments where branch_taken_ex=1 && mem_busy=0 && state!=ERROR.
  - Both saturate at all-ones; no wrap.
- Reset mid-operation: any state, including ERROR, returns to RUN with counters and flag cleared on the next edge.

Test Plan:
- Load-use: rd_ex=5, DMread_ex=1, rs1_id=5 -> one cycle of stall_if=stall_id=flush_ex=1; next cycle with DMread_ex=0 all are 0; stall_cnt=1.
- Forwarding priority: rd_me=rd_wb=7, both write enables 1, rs1_ex=7, rs2_ex=0 -> fwd_a_ex=10, fwd_b_ex=00. Then RUwrite_me=0 -> fwd_a_ex=01. Then rd_wb=0 with rs1_ex=0 -> fwd_a_ex=00.
- Branch beats load-use: luh conditions true and branch_taken_ex=1 -> flush_id=flush_ex=1, stall_if=0; flush_cnt=1.
- Memory wait: mem_busy=1 for 4 cycles (MAX_WAIT=16) -> all four stalls =1 for 4 cycles, back to RUN, timeout_err=0, stall_cnt=4. A branch_taken_ex held during the wait flushes only in cycle 5.
- Timeout: MAX_WAIT=4, mem_busy held 10 cycles -> timeout_err=1 after the 5th busy cycle; stalls stay 1 after mem_busy drops; rst_hu=1 for one cycle clears everything.
- Saturation: CNT_W=4, 20 consecutive stall cycles -> stall_cnt=15 and holds.
